// File: rtl/x_mux_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : x_mux_sweep_ctrl
//  Brief    : Tap sweep sequencer for the mux-trigger delay line. Settles each
//             tap, arms the line for N samples, accumulates one count per tap
//             and returns it over a valid/ready result port.
//  Config   : X_SWEEP_POPCOUNT_EN selects popcount accumulation (else bit 31)
//  Revision : 1.0  initial release
// ============================================================================
module x_mux_sweep_ctrl #(
    parameter int P_SEL_W  = 5,
    parameter int P_CNT_W  = 16,
    parameter int P_SETTLE = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [P_SEL_W-1:0] i_sel_lo,
    input  logic [P_SEL_W-1:0] i_sel_hi,
    input  logic [P_CNT_W-1:0] i_samples,
    output logic [P_SEL_W-1:0] o_sel,
    output logic               o_arm,
    input  logic [31:0]        i_data,
    output logic               o_busy,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [P_SEL_W-1:0] o_res_sel,
    output logic [P_CNT_W+5:0] o_res_cnt,
    output logic               o_done
);

    localparam int c_acc_w = P_CNT_W + 6;
    localparam int c_set_w = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
    localparam logic [c_set_w-1:0] c_set_last = c_set_w'(P_SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_REPORT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [P_SEL_W-1:0]   r_sel;
    logic [P_SEL_W-1:0]   r_sel_hi;
    logic [P_CNT_W-1:0]   r_samp_last;
    logic [P_CNT_W-1:0]   r_samp_cnt;
    logic [c_set_w-1:0]   r_settle_cnt;
    logic [c_acc_w-1:0]   r_acc;
    logic [5:0]           w_inc;
    logic [c_acc_w:0]     w_sum;
    logic [c_acc_w-1:0]   w_acc_sat;
    logic                 w_last_tap;
    logic                 w_settle_end;
    logic                 w_sample_end;

`ifdef X_SWEEP_POPCOUNT_EN
    always_comb begin
        w_inc = '0;
        for (int i = 0; i < 32; i++) begin
            w_inc = w_inc + 6'(i_data[i]);
        end
    end
`else
    logic w_data_unused;
    assign w_inc         = {5'd0, i_data[31]};
    assign w_data_unused = ^i_data[30:0];
`endif

    // Saturating accumulate: a carry out of the top bit pins the count at all-ones.
    assign w_sum        = {1'b0, r_acc} + (c_acc_w + 1)'(w_inc);
    assign w_acc_sat    = w_sum[c_acc_w] ? '1 : w_sum[c_acc_w-1:0];
    assign w_last_tap   = (r_sel == r_sel_hi);
    assign w_settle_end = (r_settle_cnt == c_set_last);
    assign w_sample_end = (r_samp_cnt == r_samp_last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_sel_lo > i_sel_hi) ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_settle_end) w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (w_sample_end) w_state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (i_res_ready) w_state_nxt = w_last_tap ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel        <= '0;
            r_sel_hi     <= '0;
            r_samp_last  <= '0;
            r_samp_cnt   <= '0;
            r_settle_cnt <= '0;
            r_acc        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sel        <= i_sel_lo;
                        r_sel_hi     <= i_sel_hi;
                        // Zero samples behaves as one: store the index of the last armed cycle.
                        r_samp_last  <= (i_samples == '0) ? '0 : i_samples - P_CNT_W'(1);
                        r_samp_cnt   <= '0;
                        r_settle_cnt <= '0;
                        r_acc        <= '0;
                    end
                end
                S_SETTLE: begin
                    r_settle_cnt <= w_settle_end ? '0 : r_settle_cnt + c_set_w'(1);
                end
                S_SAMPLE: begin
                    r_acc      <= w_acc_sat;
                    r_samp_cnt <= w_sample_end ? '0 : r_samp_cnt + P_CNT_W'(1);
                end
                S_REPORT: begin
                    // The final tap holds its select so the increment never wraps.
                    if (i_res_ready && !w_last_tap) begin
                        r_sel <= r_sel + P_SEL_W'(1);
                        r_acc <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_sel       = r_sel;
    assign o_arm       = (r_state == S_SAMPLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_res_valid = (r_state == S_REPORT);
    assign o_res_sel   = r_sel;
    assign o_res_cnt   = r_acc;
    assign o_done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_x_mux_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x_mux_sweep_ctrl
//  Brief    : Scoreboard bench for x_mux_sweep_ctrl (tap sweeps, backpressure,
//             empty sweep, top tap, mid-sweep reset, back-to-back starts).
//  Revision : 1.0  initial release
// ============================================================================
module tb_x_mux_sweep_ctrl;

    localparam int c_sel_w = 5;
    localparam int c_cnt_w = 16;
    localparam int c_acc_w = c_cnt_w + 6;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_start = 1'b0;
    logic [c_sel_w-1:0] i_sel_lo = '0;
    logic [c_sel_w-1:0] i_sel_hi = '0;
    logic [c_cnt_w-1:0] i_samples = '0;
    logic [c_sel_w-1:0] o_sel;
    logic               o_arm;
    logic [31:0]        i_data = '0;
    logic               o_busy;
    logic               o_res_valid;
    logic               i_res_ready = 1'b0;
    logic [c_sel_w-1:0] o_res_sel;
    logic [c_acc_w-1:0] o_res_cnt;
    logic               o_done;

    int total = 0;
    int bad   = 0;

    logic [c_sel_w-1:0] q_sel[$];
    logic [c_acc_w-1:0] q_cnt[$];

    x_mux_sweep_ctrl #(
        .P_SEL_W  (c_sel_w),
        .P_CNT_W  (c_cnt_w),
        .P_SETTLE (4)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_sel_lo    (i_sel_lo),
        .i_sel_hi    (i_sel_hi),
        .i_samples   (i_samples),
        .o_sel       (o_sel),
        .o_arm       (o_arm),
        .i_data      (i_data),
        .o_busy      (o_busy),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_sel   (o_res_sel),
        .o_res_cnt   (o_res_cnt),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic int f_of(input logic [31:0] d);
`ifdef X_SWEEP_POPCOUNT_EN
        return $countones(d);
`else
        return int'(d[31]);
`endif
    endfunction

    // mode 0: constant data; mode 1: data alternates with zero every cycle (even sample counts).
    task automatic run_sweep(input string name, input int lo, input int hi, input int ns,
                             input logic [31:0] data, input int mode, input int stall,
                             input int noise);
        int n_eff, exp_res, exp_arms, results, dones, arms, busy_cyc, oob, cyc;
        bit finished, stall_done;
        logic [c_sel_w-1:0] hs, es;
        logic [c_acc_w-1:0] hc, ec, exp_cnt;

        n_eff    = (ns == 0) ? 1 : ns;
        exp_cnt  = (mode == 0) ? c_acc_w'(n_eff * f_of(data)) : c_acc_w'((n_eff / 2) * f_of(data));
        exp_res  = (lo <= hi) ? (hi - lo + 1) : 0;
        exp_arms = exp_res * n_eff;
        for (int t = lo; t <= hi; t++) begin
            q_sel.push_back(c_sel_w'(t));
            q_cnt.push_back(exp_cnt);
        end
        results = 0; dones = 0; arms = 0; busy_cyc = 0; oob = 0;
        finished   = 1'b0;
        stall_done = (stall == 0);
        i_res_ready = (stall == 0);
        i_data    = data;
        i_sel_lo  = c_sel_w'(lo);
        i_sel_hi  = c_sel_w'(hi);
        i_samples = c_cnt_w'(ns);
        i_start   = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;

        for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (o_busy) busy_cyc++;
            if (o_arm) arms++;
            if (o_busy && lo <= hi && (int'(o_sel) < lo || int'(o_sel) > hi)) oob++;
            if (o_done) dones++;
            if (o_res_valid && !stall_done) begin
                hs = o_res_sel;
                hc = o_res_cnt;
                for (int k = 0; k < stall; k++) begin
                    @(posedge i_clk); #1;
                    total++;
                    if (o_res_valid !== 1'b1 || o_res_sel !== hs || o_res_cnt !== hc || o_arm !== 1'b0) begin
                        bad++;
                        $display("FAIL %s stall_hold cyc=%0d got valid=%b sel=%0d cnt=%0d arm=%b exp valid=1 sel=%0d cnt=%0d arm=0",
                                 name, k, o_res_valid, o_res_sel, o_res_cnt, o_arm, hs, hc);
                    end
                end
                stall_done  = 1'b1;
                i_res_ready = 1'b1;
            end
            if (o_res_valid && i_res_ready) begin
                results++;
                total++;
                if (q_sel.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_result got sel=%0d cnt=%0d exp none", name, o_res_sel, o_res_cnt);
                end else begin
                    es = q_sel.pop_front();
                    ec = q_cnt.pop_front();
                    if (o_res_sel !== es || o_res_cnt !== ec) begin
                        bad++;
                        $display("FAIL %s result got sel=%0d cnt=%0d exp sel=%0d cnt=%0d",
                                 name, o_res_sel, o_res_cnt, es, ec);
                    end
                end
            end
            if (noise != 0) begin
                i_start   = o_busy && !o_done;
                i_sel_lo  = c_sel_w'($urandom);
                i_sel_hi  = c_sel_w'($urandom);
                i_samples = c_cnt_w'($urandom_range(0, 7));
            end
            if (mode != 0) i_data = (i_data == data) ? 32'h0 : data;
            if (o_done) finished = 1'b1;
            @(posedge i_clk); #1;
        end
        i_start = 1'b0;

        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s timeout got done=0 exp done pulse", name);
        end
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done got busy=%b done=%b exp 0 0", name, o_busy, o_done);
        end
        total++;
        if (results != exp_res || dones != 1 || arms != exp_arms) begin
            bad++;
            $display("FAIL %s counts got results=%0d dones=%0d arms=%0d exp %0d 1 %0d",
                     name, results, dones, arms, exp_res, exp_arms);
        end
        total++;
        if (oob != 0) begin
            bad++;
            $display("FAIL %s sel_range got out_of_range=%0d exp 0", name, oob);
        end
        if (lo > hi) begin
            total++;
            if (busy_cyc != 1) begin
                bad++;
                $display("FAIL %s busy_len got %0d exp 1", name, busy_cyc);
            end
        end
        total++;
        if (q_sel.size() != 0) begin
            bad++;
            $display("FAIL %s missing_results got left=%0d exp 0", name, q_sel.size());
            q_sel.delete();
            q_cnt.delete();
        end
        i_res_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (o_sel !== '0 || o_arm !== 1'b0 || o_busy !== 1'b0 || o_res_valid !== 1'b0 ||
            o_res_sel !== '0 || o_res_cnt !== '0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL %s outputs got sel=%0d arm=%b busy=%b valid=%b rsel=%0d cnt=%0d done=%b exp all 0",
                     name, o_sel, o_arm, o_busy, o_res_valid, o_res_sel, o_res_cnt, o_done);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset_held");
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check_all_zero("reset_idle");
    endtask

    task automatic test_sweep_basic();
        run_sweep("basic", 3, 5, 4, 32'h8000_FFFF, 0, 0, 0);
    endtask

    task automatic test_toggle();
        run_sweep("toggle", 3, 5, 4, 32'hFFFF_FFFF, 1, 0, 0);
    endtask

    task automatic test_inverted();
        run_sweep("inverted", 7, 2, 4, 32'hFFFF_FFFF, 0, 0, 0);
    endtask

    task automatic test_top_tap();
        run_sweep("top_tap", 31, 31, 0, 32'hC000_0001, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_sweep("stall", 10, 12, 3, 32'h8F0F_0F0F, 0, 50, 0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit found;
        int dones;
        found = 1'b0;
        i_res_ready = 1'b1;
        i_data    = 32'hFFFF_FFFF;
        i_sel_lo  = 5'd3;
        i_sel_hi  = 5'd5;
        i_samples = 16'd8;
        i_start   = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (cyc = 0; cyc < 200 && !found; cyc++) begin
            if (o_arm && o_sel == 5'd4) found = 1'b1;
            else begin
                @(posedge i_clk); #1;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reset_mid reach_tap2 got not_found exp armed at sel=4");
        end
        #2;
        i_rst = 1'b1;
        #1;
        check_all_zero("reset_mid_async");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_done || o_busy) dones++;
            @(posedge i_clk); #1;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL reset_mid quiet got busy_or_done_cycles=%0d exp 0", dones);
        end
        run_sweep("after_reset", 3, 5, 4, 32'h8000_00FF, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_sweep("b2b_a", 0, 2, 2, 32'h0001_8000, 0, 0, 1);
        run_sweep("b2b_b", 29, 31, 6, 32'hF000_000F, 1, 0, 1);
    endtask

    initial begin
        test_reset();
        test_sweep_basic();
        test_toggle();
        test_inverted();
        test_top_tap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
